// File: rtl/kronos_writeback.sv
// kronos_writeback: EX->WB consumer stage that retires register writes, branch redirects, traps and load/store bus accesses
package kronos_wb_pkg;
   typedef struct packed {
      logic [4:0]  rd;
      logic        rd_write;
      logic        branch;
      logic        branch_cond;
      logic        ld;
      logic        st;
      logic [1:0]  data_size;
      logic        data_uns;
      logic        illegal;
      logic [31:0] result1;
      logic [31:0] result2;
   } pipeEXWB_t;
endpackage

module kronos_writeback
   import kronos_wb_pkg::*;
(
   input  logic        clk,
   input  logic        rstz,
   input  pipeEXWB_t   execute,
   input  logic        pipe_in_vld,
   output logic        pipe_in_rdy,
   output logic [31:0] regwr_data,
   output logic [4:0]  regwr_sel,
   output logic        regwr_en,
   output logic [31:0] fwd_data,
   output logic        fwd_vld,
   output logic [31:0] branch_target,
   output logic        branch_vld,
   output logic        trap,
   output logic [31:0] data_addr,
   output logic        data_req,
   output logic        data_wr_en,
   output logic [3:0]  data_mask,
   output logic [31:0] data_wr_data,
   input  logic [31:0] data_rd_data,
   input  logic        data_ack
);
   typedef enum logic {STEADY, LSU} state_t;
   state_t      state, state_next;
   logic        accept, mem, misaligned, fault;
   logic [1:0]  off;
   logic [3:0]  mask;
   logic        ld_pend, ld_uns, ld_wr;
   logic [1:0]  ld_size, ld_off;
   logic [4:0]  ld_rd;
   logic [31:0] lane, ld_data;

   assign fwd_data = regwr_data;
   assign fwd_vld  = regwr_en;

   // decode the incoming packet, extend returning load data and pick the next FSM state
   always_comb begin
      off        = execute.result1[1:0];
      accept     = pipe_in_vld && pipe_in_rdy;
      mem        = execute.ld || execute.st;
      misaligned = mem && ((execute.data_size == 2'd0) ? 1'b0 :
                           (execute.data_size == 2'd1) ? off[0] : (off != 2'd0));
      fault      = execute.illegal || misaligned;
      mask       = (execute.data_size == 2'd0) ? 4'b0001 << off :
                   (execute.data_size == 2'd1) ? 4'b0011 << off : 4'hF;
      lane       = data_rd_data >> {ld_off, 3'b000};
      ld_data    = (ld_size == 2'd0) ? {{24{~ld_uns & lane[7]}}, lane[7:0]} :
                   (ld_size == 2'd1) ? {{16{~ld_uns & lane[15]}}, lane[15:0]} : data_rd_data;
      state_next = state;
      if (state == STEADY && accept && mem && !fault)
         state_next = LSU;
      else if (state == LSU && data_ack)
         state_next = STEADY;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rstz)
      if (!rstz) state <= STEADY;
      else       state <= state_next;

   // registered strobes, bus signals and held data outputs
   always_ff @(posedge clk or negedge rstz)
      if (!rstz) begin
         pipe_in_rdy   <= 1'b0;
         regwr_data    <= '0;
         regwr_sel     <= '0;
         regwr_en      <= 1'b0;
         branch_target <= '0;
         branch_vld    <= 1'b0;
         trap          <= 1'b0;
         data_addr     <= '0;
         data_req      <= 1'b0;
         data_wr_en    <= 1'b0;
         data_mask     <= '0;
         data_wr_data  <= '0;
         ld_pend       <= 1'b0;
         ld_uns        <= 1'b0;
         ld_wr         <= 1'b0;
         ld_size       <= '0;
         ld_off        <= '0;
         ld_rd         <= '0;
      end else begin
         regwr_en    <= 1'b0;
         branch_vld  <= 1'b0;
         trap        <= 1'b0;
         pipe_in_rdy <= state_next == STEADY;
         if (state == LSU) begin
            if (data_ack) begin
               data_req <= 1'b0;
               if (ld_pend && ld_wr) begin
                  regwr_en   <= 1'b1;
                  regwr_sel  <= ld_rd;
                  regwr_data <= ld_data;
               end
            end
         end else if (accept) begin
            if (fault)
               trap <= 1'b1;
            else if (mem) begin
               data_req     <= 1'b1;
               data_addr    <= {execute.result1[31:2], 2'b00};
               data_wr_en   <= execute.st;
               data_mask    <= mask;
               data_wr_data <= execute.result2 << {off, 3'b000};
               ld_pend      <= execute.ld && !execute.st;
               ld_uns       <= execute.data_uns;
               ld_wr        <= execute.rd_write;
               ld_size      <= execute.data_size;
               ld_off       <= off;
               ld_rd        <= execute.rd;
            end else if (execute.branch_cond) begin
               if (execute.result1[0]) begin
                  branch_vld    <= 1'b1;
                  branch_target <= execute.result2;
               end
            end else begin
               if (execute.branch) begin
                  branch_vld    <= 1'b1;
                  branch_target <= execute.result2;
               end
               if (execute.rd_write) begin
                  regwr_en   <= 1'b1;
                  regwr_sel  <= execute.rd;
                  regwr_data <= execute.result1;
               end
            end
         end
      end
endmodule

// File: tb/tb_kronos_writeback.sv
// tb_kronos_writeback: directed self-checking bench for the write-back stage
module tb_kronos_writeback;
   import kronos_wb_pkg::*;

   logic        clk = 1'b0;
   logic        rstz;
   pipeEXWB_t   execute;
   logic        pipe_in_vld;
   logic        pipe_in_rdy;
   logic [31:0] regwr_data;
   logic [4:0]  regwr_sel;
   logic        regwr_en;
   logic [31:0] fwd_data;
   logic        fwd_vld;
   logic [31:0] branch_target;
   logic        branch_vld;
   logic        trap;
   logic [31:0] data_addr;
   logic        data_req;
   logic        data_wr_en;
   logic [3:0]  data_mask;
   logic [31:0] data_wr_data;
   logic [31:0] data_rd_data;
   logic        data_ack;
   int          tests = 0;
   int          fails = 0;

   kronos_writeback dut (
      .clk(clk), .rstz(rstz), .execute(execute), .pipe_in_vld(pipe_in_vld), .pipe_in_rdy(pipe_in_rdy),
      .regwr_data(regwr_data), .regwr_sel(regwr_sel), .regwr_en(regwr_en),
      .fwd_data(fwd_data), .fwd_vld(fwd_vld),
      .branch_target(branch_target), .branch_vld(branch_vld), .trap(trap),
      .data_addr(data_addr), .data_req(data_req), .data_wr_en(data_wr_en), .data_mask(data_mask),
      .data_wr_data(data_wr_data), .data_rd_data(data_rd_data), .data_ack(data_ack)
   );

   always #5 clk = ~clk;

   function automatic pipeEXWB_t mk(input logic [4:0] rd, input logic rw, input logic br, input logic bc,
                                    input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                                    input logic ill, input logic [31:0] r1, input logic [31:0] r2);
      pipeEXWB_t p;
      p.rd = rd; p.rd_write = rw; p.branch = br; p.branch_cond = bc;
      p.ld = ld; p.st = st; p.data_size = sz; p.data_uns = uns; p.illegal = ill;
      p.result1 = r1; p.result2 = r2;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input pipeEXWB_t p);
      execute = p;
      pipe_in_vld = 1'b1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rstz = 1'b0; execute = '0; pipe_in_vld = 1'b0; data_ack = 1'b0; data_rd_data = '0;
      repeat (2) tick();
      chk("rst_rdy", pipe_in_rdy, 0);
      chk("rst_req", data_req, 0);
      chk("rst_regwr", regwr_en, 0);
      chk("rst_data", regwr_data, 0);
      chk("rst_trap", trap, 0);
      rstz = 1'b1;
      chk("rel_rdy0", pipe_in_rdy, 0);
      tick();
      chk("rel_rdy1", pipe_in_rdy, 1);

      // ALU stream
      drive(mk(5, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0)); tick();
      chk("alu0_en", regwr_en, 1); chk("alu0_fwd", fwd_vld, 1); chk("alu0_sel", regwr_sel, 5);
      chk("alu0_data", regwr_data, 1); chk("alu0_rdy", pipe_in_rdy, 1);
      drive(mk(6, 1, 0, 0, 0, 0, 2, 0, 0, 2, 0)); tick();
      chk("alu1_en", regwr_en, 1); chk("alu1_sel", regwr_sel, 6); chk("alu1_fwd", fwd_data, 2);
      drive(mk(7, 1, 0, 0, 0, 0, 2, 0, 0, 3, 0)); tick();
      chk("alu2_en", regwr_en, 1); chk("alu2_sel", regwr_sel, 7); chk("alu2_data", regwr_data, 3);
      chk("alu2_rdy", pipe_in_rdy, 1);
      pipe_in_vld = 1'b0; tick();
      chk("alu_idle_en", regwr_en, 0);

      // lb 0x103, two wait cycles
      drive(mk(8, 1, 0, 0, 1, 0, 0, 0, 0, 32'h103, 0)); tick(); pipe_in_vld = 1'b0;
      data_rd_data = 32'h80FF_FFFF;
      chk("lb_req", data_req, 1); chk("lb_addr", data_addr, 32'h100); chk("lb_mask", data_mask, 4'b1000);
      chk("lb_wren", data_wr_en, 0); chk("lb_rdy", pipe_in_rdy, 0);
      tick();
      chk("lb_wait1_req", data_req, 1); chk("lb_wait1_en", regwr_en, 0);
      tick();
      chk("lb_wait2_req", data_req, 1);
      data_ack = 1'b1; tick(); data_ack = 1'b0;
      chk("lb_done_req", data_req, 0); chk("lb_en", regwr_en, 1); chk("lb_sel", regwr_sel, 8);
      chk("lb_data", regwr_data, 32'hFFFF_FF80); chk("lb_rdy1", pipe_in_rdy, 1);
      tick();
      chk("lb_pulse", regwr_en, 0);

      // lbu same access, ack after 2 waits
      drive(mk(8, 1, 0, 0, 1, 0, 0, 1, 0, 32'h103, 0)); tick(); pipe_in_vld = 1'b0;
      tick(); tick();
      data_ack = 1'b1; tick(); data_ack = 1'b0;
      chk("lbu_en", regwr_en, 1); chk("lbu_data", regwr_data, 32'h0000_0080);

      // lh 0x102, ack in first request cycle
      drive(mk(9, 1, 0, 0, 1, 0, 1, 0, 0, 32'h102, 0)); tick(); pipe_in_vld = 1'b0;
      data_rd_data = 32'h7FFF_0000;
      chk("lh_req", data_req, 1); chk("lh_mask", data_mask, 4'b1100);
      data_ack = 1'b1; tick(); data_ack = 1'b0;
      chk("lh_req0", data_req, 0); chk("lh_en", regwr_en, 1); chk("lh_data", regwr_data, 32'h0000_7FFF);

      // sb 0x201
      drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h201, 32'hAB)); tick(); pipe_in_vld = 1'b0;
      chk("sb_req", data_req, 1); chk("sb_wren", data_wr_en, 1); chk("sb_addr", data_addr, 32'h200);
      chk("sb_mask", data_mask, 4'b0010); chk("sb_wdata", data_wr_data, 32'h0000_AB00);
      chk("sb_rdy", pipe_in_rdy, 0);
      tick();
      chk("sb_wait_rdy", pipe_in_rdy, 0);
      data_ack = 1'b1; tick(); data_ack = 1'b0;
      chk("sb_req0", data_req, 0); chk("sb_noreg", regwr_en, 0); chk("sb_rdy1", pipe_in_rdy, 1);

      // ack in STEADY is ignored
      data_ack = 1'b1; tick(); data_ack = 1'b0;
      chk("ack_idle_req", data_req, 0); chk("ack_idle_en", regwr_en, 0); chk("ack_idle_rdy", pipe_in_rdy, 1);

      // branches
      drive(mk(0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 32'h400)); tick();
      chk("bc_taken", branch_vld, 1); chk("bc_target", branch_target, 32'h400); chk("bc_noreg", regwr_en, 0);
      drive(mk(0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 32'h800)); tick();
      chk("bc_not", branch_vld, 0); chk("bc_hold", branch_target, 32'h400);
      drive(mk(1, 1, 1, 0, 0, 0, 2, 0, 0, 32'h104, 32'h500)); tick(); pipe_in_vld = 1'b0;
      chk("jal_vld", branch_vld, 1); chk("jal_target", branch_target, 32'h500);
      chk("jal_en", regwr_en, 1); chk("jal_sel", regwr_sel, 1); chk("jal_data", regwr_data, 32'h104);
      tick();
      chk("jal_pulse", branch_vld, 0);

      // traps
      drive(mk(3, 1, 0, 0, 1, 0, 2, 0, 0, 32'h102, 0)); tick();
      chk("lw_mis_trap", trap, 1); chk("lw_mis_req", data_req, 0); chk("lw_mis_en", regwr_en, 0);
      chk("lw_mis_rdy", pipe_in_rdy, 1);
      drive(mk(3, 1, 0, 0, 0, 0, 2, 0, 1, 32'h77, 0)); tick(); pipe_in_vld = 1'b0;
      chk("ill_trap", trap, 1); chk("ill_en", regwr_en, 0); chk("ill_req", data_req, 0);
      tick();
      chk("trap_pulse", trap, 0); chk("trap_noreq", data_req, 0);

      // reset while in LSU
      drive(mk(4, 1, 0, 0, 1, 0, 2, 0, 0, 32'h300, 0)); tick(); pipe_in_vld = 1'b0;
      chk("rlsu_req1", data_req, 1);
      #1 rstz = 1'b0;
      #1;
      chk("rlsu_async_req", data_req, 0); chk("rlsu_rdy", pipe_in_rdy, 0);
      tick();
      rstz = 1'b1;
      tick();
      chk("rlsu_rdy1", pipe_in_rdy, 1);
      drive(mk(9, 1, 0, 0, 0, 0, 2, 0, 0, 32'h55, 0)); tick(); pipe_in_vld = 1'b0;
      chk("rlsu_alu_en", regwr_en, 1); chk("rlsu_alu_sel", regwr_sel, 9); chk("rlsu_alu_data", regwr_data, 32'h55);
      chk("rlsu_noreq", data_req, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
